// File: rtl/regread_port.sv
// regread_port
//   Register-read stage with a scoreboard. Reads two source registers out of a
//   flattened register array, forwards same-cycle write data, stalls on
//   registers with a pending write, and returns the pair one cycle after
//   acceptance over a valid/ready result port.
//
//   Ports
//     clk, resetn           clock, asynchronous active-low reset
//     regs                  32 x (XLEN+1) register array, reg i at [i*(XLEN+1) +: XLEN+1]
//     G, R_in               write data and one-hot write enables (bit 0 ignored)
//     req_valid/req_ready   read request handshake, sources rs1/rs2
//     lock_valid/lock_addr  marks lock_addr as having a pending write
//     rd_valid/rd_ready     result handshake, data rs1_data/rs2_data
//
//   The per-source logic (hazard test + bypass mux) lives in regread_lane and
//   is replicated once per source operand.

module regread_lane #(
    parameter int DW = 33
) (
    input  logic [32*DW-1:0] regs,
    input  logic [DW-1:0]    g,
    input  logic [31:0]      wen,
    input  logic [31:0]      sb,
    input  logic [4:0]       rs,
    output logic             hit,
    output logic [DW-1:0]    data
);
    // A write landing this cycle releases the lock, so it is not a hazard;
    // the bypass below supplies the value instead.
    assign hit = (rs != 5'd0) && sb[rs] && !wen[rs];

    always_comb begin
        data = '0;
        if (rs != 5'd0) begin
            if (wen[rs]) data = g;
            else         data = regs[int'(rs)*DW +: DW];
        end
    end
endmodule

module regread_port #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [32*(XLEN+1)-1:0] regs,
    input  logic [XLEN:0]          G,
    input  logic [XLEN-1:0]        R_in,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic                   lock_valid,
    input  logic [4:0]             lock_addr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [XLEN:0]          rs1_data,
    output logic [XLEN:0]          rs2_data
);
    localparam int DW        = XLEN + 1;
    localparam int NUM_LANES = 2;

    logic [31:0]                      sb;
    logic [31:0]                      wen;
    logic [31:0]                      lock_oh;
    logic [NUM_LANES-1:0][4:0]        lane_rs;
    logic [NUM_LANES-1:0]             lane_hit;
    logic [NUM_LANES-1:0][DW-1:0]     lane_data;
    logic                             accept;
    logic                             unused_r0;

    // Register 0 is hardwired, so its write enable never matters.
    assign unused_r0 = R_in[0];

    always_comb begin
        wen = '0;
        for (int i = 1; i < 32; i++) wen[i] = R_in[i];
    end

    always_comb begin
        lock_oh = '0;
        if (lock_valid && lock_addr != 5'd0) lock_oh[lock_addr] = 1'b1;
    end

    assign lane_rs[0] = rs1;
    assign lane_rs[1] = rs2;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        regread_lane #(.DW(DW)) u_lane (
            .regs (regs),
            .g    (G),
            .wen  (wen),
            .sb   (sb),
            .rs   (lane_rs[l]),
            .hit  (lane_hit[l]),
            .data (lane_data[l])
        );
    end

    // Output slot is free if empty or being drained this cycle.
    assign req_ready = !(|lane_hit) && (!rd_valid || rd_ready);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb       <= '0;
            rd_valid <= 1'b0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            // Clear on write first, then set on lock: a same-cycle lock wins.
            // Locks taken this cycle only affect later requests.
            sb <= (sb & ~wen) | lock_oh;
            if (accept) begin
                rd_valid <= 1'b1;
                rs1_data <= lane_data[0];
                rs2_data <= lane_data[1];
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regread_port.sv
module tb_regread_port;
    localparam int XLEN = 32;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [32*(XLEN+1)-1:0] regs;
    logic [XLEN:0]          G;
    logic [XLEN-1:0]        R_in;
    logic                   req_valid, req_ready;
    logic [4:0]             rs1, rs2;
    logic                   lock_valid;
    logic [4:0]             lock_addr;
    logic                   rd_valid, rd_ready;
    logic [XLEN:0]          rs1_data, rs2_data;

    logic [32:0] regs_a [32];

    int checks = 0;
    int passed = 0;

    // reference model state
    bit          pend [32];
    bit          m_valid;
    logic [32:0] m_d1, m_d2;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 32; i++) regs[i*33 +: 33] = regs_a[i];
    end

    regread_port #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn), .regs(regs), .G(G), .R_in(R_in),
        .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
        .lock_valid(lock_valid), .lock_addr(lock_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    typedef struct {
        logic        rv;
        logic [4:0]  a, b;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] rin;
        logic [32:0] g;
        logic        rdr;
        logic        e_rdy, e_vld;
        logic [32:0] e1, e2;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input logic rv, input logic [4:0] a, input logic [4:0] b,
                         input logic lv, input logic [4:0] la, input logic [31:0] rin,
                         input logic [32:0] g, input logic rdr);
        @(negedge clk);
        req_valid = rv; rs1 = a; rs2 = b;
        lock_valid = lv; lock_addr = la;
        R_in = rin; G = g; rd_ready = rdr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [32:0] d1, input logic [32:0] d2);
        chk({name, ".rd_valid"}, 64'(rd_valid), 64'(v));
        chk({name, ".rs1_data"}, 64'(rs1_data), 64'(d1));
        chk({name, ".rs2_data"}, 64'(rs2_data), 64'(d2));
    endtask

    // behavioural reference: a register is busy while a lock is pending and
    // no write to it shows up this cycle
    function automatic bit busy(input logic [4:0] r);
        return r != 0 && pend[r] && !R_in[r];
    endfunction

    function automatic logic [32:0] value(input logic [4:0] r);
        if (r == 0)   return '0;
        if (R_in[r])  return G;
        return regs_a[r];
    endfunction

    initial begin
        bit exp_rdy;
        for (int i = 0; i < 32; i++) regs_a[i] = 33'(i) * 33'h0_0101_0101;
        regs_a[5] = 33'h0_0000_00AA;
        regs_a[7] = 33'h0;
        regs_a[9] = 33'h1_0000_0001;

        resetn = 1'b0;
        req_valid = 0; rs1 = 0; rs2 = 0; lock_valid = 0; lock_addr = 0;
        R_in = 0; G = 0; rd_ready = 1;
        #2;
        chk_out("reset", 1'b0, 33'h0, 33'h0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- table-driven single-cycle vectors ----------------
        tbl[0] = '{1, 5, 9, 0, 0, 32'h0,      33'h0,         1, 1, 1, 33'h0AA,        33'h1_0000_0001};
        tbl[1] = '{1, 7, 0, 0, 0, 32'h80,     33'h123,       1, 1, 1, 33'h123,        33'h0};
        tbl[2] = '{1, 0, 0, 1, 0, 32'h1,      33'hFFF,       1, 1, 1, 33'h0,          33'h0};
        tbl[3] = '{1, 9, 9, 0, 0, 32'h0,      33'h0,         1, 1, 1, 33'h1_0000_0001, 33'h1_0000_0001};
        tbl[4] = '{1, 5, 7, 0, 0, 32'h20,     33'h1_FFFF_FFFF, 1, 1, 1, 33'h1_FFFF_FFFF, 33'h0};
        tbl[5] = '{0, 5, 7, 0, 0, 32'h0,      33'h0,         1, 1, 0, 33'h1_FFFF_FFFF, 33'h0};
        for (int k = 0; k < 6; k++) begin
            drive(tbl[k].rv, tbl[k].a, tbl[k].b, tbl[k].lv, tbl[k].la, tbl[k].rin, tbl[k].g, tbl[k].rdr);
            #1;
            chk($sformatf("vec%0d.req_ready", k), 64'(req_ready), 64'(tbl[k].e_rdy));
            tick();
            chk_out($sformatf("vec%0d", k), tbl[k].e_vld, tbl[k].e1, tbl[k].e2);
        end

        // ---------------- scoreboard stall until write ----------------
        drive(0, 0, 0, 1, 3, 0, 0, 1); tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 3, 0, 0, 0, 0, 1); #1;
            chk("stall.req_ready", 64'(req_ready), 64'd0);
            tick();
            chk("stall.rd_valid", 64'(rd_valid), 64'd0);
        end
        drive(1, 0, 3, 0, 0, 32'h8, 33'h55, 1); #1;
        chk("release.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("release", 1'b1, 33'h0, 33'h55);
        drive(1, 3, 0, 0, 0, 0, 0, 1); #1;
        chk("cleared.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("cleared", 1'b1, 33'h0_0303_0303, 33'h0);

        // ---------------- lock in same cycle as request ----------------
        drive(1, 6, 0, 1, 6, 0, 0, 1); #1;
        chk("samelock.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("samelock", 1'b1, 33'h0_0606_0606, 33'h0);
        drive(1, 6, 0, 0, 0, 0, 0, 1); #1;
        chk("afterlock.req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("afterlock.rd_valid", 64'(rd_valid), 64'd0);
        drive(0, 0, 0, 0, 0, 32'h40, 33'h0, 1); tick();

        // ---------------- backpressure ----------------
        drive(1, 5, 9, 0, 0, 0, 0, 0); #1;
        chk("bp.first.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("bp.first", 1'b1, 33'h0AA, 33'h1_0000_0001);
        for (int k = 0; k < 4; k++) begin
            drive(1, 9, 5, 0, 0, 0, 0, 0); #1;
            chk("bp.hold.req_ready", 64'(req_ready), 64'd0);
            tick();
            chk_out("bp.hold", 1'b1, 33'h0AA, 33'h1_0000_0001);
        end
        drive(1, 9, 5, 0, 0, 0, 0, 1); #1;
        chk("bp.drain.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("bp.b2b", 1'b1, 33'h1_0000_0001, 33'h0AA);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("bp.empty.rd_valid", 64'(rd_valid), 64'd0);

        // ---------------- reset while holding a result ----------------
        drive(1, 5, 9, 1, 4, 0, 0, 0); tick();
        chk("rst.hold.rd_valid", 64'(rd_valid), 64'd1);
        drive(1, 4, 0, 0, 0, 0, 0, 0); #1;
        chk("rst.locked.req_ready", 64'(req_ready), 64'd0);
        #1 resetn = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 33'h0, 33'h0);
        #1 resetn = 1'b1;
        #0;
        chk("rst.after.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk_out("rst.after", 1'b1, 33'h0_0404_0404, 33'h0);

        // ---------------- randomized run against reference model ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        resetn = 1'b0;
        #1 resetn = 1'b1;
        foreach (pend[i]) pend[i] = 0;
        m_valid = 0; m_d1 = '0; m_d2 = '0;
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] rin;
            logic        accept;
            rin = 0;
            if ($urandom_range(0, 9) < 3) rin[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 15) == 0)
                regs_a[$urandom_range(1, 31)] = {1'($urandom), 32'($urandom)};
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), rin,
                  {1'($urandom), 32'($urandom)}, 1'($urandom_range(0, 9) < 7));
            #1;
            exp_rdy = !busy(rs1) && !busy(rs2) && (!m_valid || rd_ready);
            chk("rand.req_ready", 64'(req_ready), 64'(exp_rdy));
            accept = req_valid && exp_rdy;
            if (accept) begin
                m_valid = 1; m_d1 = value(rs1); m_d2 = value(rs2);
            end else if (rd_ready) begin
                m_valid = 0;
            end
            for (int r = 1; r < 32; r++) begin
                if (lock_valid && lock_addr == r) pend[r] = 1;
                else if (R_in[r])                 pend[r] = 0;
            end
            tick();
            chk_out("rand", m_valid, m_d1, m_d2);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regread_port.md
REGREAD_PORT -- requirements
Module: regread_port

Interface
REQ-001 SHALL have parameter XLEN, default 32; register data width is XLEN+1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port regs, input, 32*(XLEN+1); flattened register-array outputs, register i at bits [i*(XLEN+1) +: XLEN+1].
REQ-005 SHALL have port G, input, XLEN+1; the write data presented to the register array this cycle.
REQ-006 SHALL have port R_in, input, XLEN; the one-hot write enables to the register array; bit 0 is ignored.
REQ-007 SHALL have ports req_valid (input, 1), req_ready (output, 1), rs1 (input, 5) and rs2 (input, 5); the read-request handshake and source addresses.
REQ-008 SHALL have ports lock_valid (input, 1) and lock_addr (input, 5); these mark a destination register as having a pending write.
REQ-009 SHALL have ports rd_valid (output, 1), rd_ready (input, 1), rs1_data (output, XLEN+1) and rs2_data (output, XLEN+1); the read-result handshake.

Function
REQ-010 SHALL hold a 32-bit scoreboard sb; bit 0 is permanently 0.
REQ-011 SHALL update sb each cycle as follows:
- sb_next = (sb & ~{R_in[31:1],1'b0}) | lock_onehot.
- lock_onehot is set only when lock_valid=1 and lock_addr!=0.
- If a lock and a write to the same address occur in the same cycle, the set wins.
REQ-012 SHALL compute hit(rs) = (rs!=0) & sb[rs] & ~R_in[rs]; a write clearing the bit in the same cycle is not a hit.
REQ-013 SHALL drive req_ready = ~hit(rs1) & ~hit(rs2) & (~rd_valid | rd_ready), combinationally.
REQ-014 SHALL accept a request on a cycle with req_valid & req_ready; rd_valid=1 and both data outputs are registered on that edge (latency 1 cycle).
REQ-015 SHALL capture the data for each source as follows:
- rs==0 gives 0.
- Otherwise, if R_in[rs]=1, it gives G (write bypass).
- Otherwise it gives regs[rs].
REQ-016 SHALL hold rd_valid, rs1_data and rs2_data stable while rd_valid=1 and rd_ready=0.
REQ-017 SHALL clear rd_valid on the edge where rd_valid & rd_ready and no new request is accepted.
REQ-018 SHALL keep rd_valid=1 and load the new data when a request is accepted in the same cycle as the output is consumed (back-to-back, full throughput).
REQ-019 SHALL evaluate a lock arriving in the same cycle as a request against the pre-update sb; the lock affects only later requests.
REQ-020 SHALL allow rs1==rs2; both outputs then carry identical data.
REQ-021 SHALL NOT latch stalled requests; a request with req_ready=0 leaves all state except sb unchanged.

Reset
REQ-022 SHALL, while resetn=0 and independent of clk, force rd_valid=0, rs1_data=0, rs2_data=0 and sb=0.
REQ-023 SHALL discard any pending result and all scoreboard locks when resetn is asserted mid-operation.
REQ-024 SHALL drive req_ready=1 during the first cycle after resetn deasserts, provided rd_valid=0.

Verification
REQ-025 Plain read: regs[5]=0x00000_0AA, regs[9]=0x1_0000_0001; request rs1=5, rs2=9, rd_ready=1 -> next cycle rd_valid=1, rs1_data=0x0AA, rs2_data=0x1_0000_0001.
REQ-026 Bypass: request rs1=7 while R_in=1<<7, G=0x123, regs[7]=0x0 -> rs1_data=0x123.
REQ-027 Scoreboard stall: lock_addr=3; request rs2=3 next cycle -> req_ready=0 until the cycle where R_in[3]=1 (G=0x55), which is accepted with rs2_data=0x55.
REQ-028 Backpressure: rd_ready=0 for 4 cycles after a result -> req_ready=0 and outputs unchanged; the first cycle with rd_ready=1 accepts the queued request.
REQ-029 Register zero: lock_addr=0, R_in[0]=1, G=0xFFF, request rs1=0 -> accepted immediately, rs1_data=0.
REQ-030 Reset mid-hold: rd_valid=1 and sb[4]=1, pulse resetn low -> rd_valid=0, data=0, and a request with rs1=4 is accepted on the next cycle.
